// File: rtl/sseg_scanner.sv
// sseg_scanner: multiplexed seven-segment driver with frame-aligned double-buffered load.
// Optional per-digit blinking is built only when SSEG_BLINK_EN is defined.
`default_nettype none

module sseg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1024,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk_out,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink,
    output logic                    load_ack,
    output logic                    frame_done,
    output logic [7:0]              sseg,
    output logic [NUM_DIGITS-1:0]   AN
);

    localparam int CNT_W = $clog2(DWELL_CYCLES);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, disp_q, disp_d;
    logic [NUM_DIGITS-1:0]   sdp_q, sdp_d, ddp_q, ddp_d;
    logic                    pending_q, pending_d;
    logic                    load_ack_q, load_ack_d;
    logic                    frame_done_q, frame_done_d;
    logic [7:0]              sseg_q, sseg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    boundary;
    logic                    idx_valid;
    logic                    blink_hide;
    logic [NUM_DIGITS-1:0]   lz_mask;

    // Active-low glyphs, bit order G,F,E,D,C,B,A,p with p left off (1).
    function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0: g = 8'h81;
            4'h1: g = 8'hF3;
            4'h2: g = 8'h49;
            4'h3: g = 8'h61;
            4'h4: g = 8'h33;
            4'h5: g = 8'h25;
            4'h6: g = 8'h05;
            4'h7: g = 8'hF1;
            4'h8: g = 8'h01;
            4'h9: g = 8'h21;
            4'hA: g = 8'h11;
            4'hB: g = 8'h07;
            4'hC: g = 8'h8D;
            4'hD: g = 8'h43;
            4'hE: g = 8'h0D;
            default: g = 8'h1D;
        endcase
        return g;
    endfunction

    assign idx_valid = (32'(idx_q) < NUM_DIGITS);
    assign boundary  = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

    // Digit k is a leading zero when it and every nibble above it are zero.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        lz_mask    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (disp_q[4*k +: 4] == 4'h0);
            lz_mask[k] = blank_lz && upper_zero && (k != 0);
        end
    end

`ifdef SSEG_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic            phase_q, phase_d;

    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (boundary) begin
            if (fcnt_q == FC_LAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_out) begin
        if (reset) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_hide = phase_q && idx_valid && blink[idx_q];
`else
    logic blink_unused;
    assign blink_unused = ^blink;
    assign blink_hide   = 1'b0;
`endif

    always_comb begin
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        sdp_d        = sdp_q;
        disp_d       = disp_q;
        ddp_d        = ddp_q;
        pending_d    = pending_q;
        load_ack_d   = 1'b0;
        frame_done_d = boundary;
        an_d         = '1;
        sseg_d       = 8'hFF;

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (!idx_valid) begin
            idx_d = '0;
        end

        // A load on the boundary edge bypasses the shadow and lands directly.
        if (boundary) begin
            if (load) begin
                disp_d     = value;
                ddp_d      = dp;
                load_ack_d = 1'b1;
            end else if (pending_q) begin
                disp_d     = shadow_q;
                ddp_d      = sdp_q;
                load_ack_d = 1'b1;
            end
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d  = value;
            sdp_d     = dp;
            pending_d = 1'b1;
        end

        if (idx_valid && (cnt_q != '0)) begin
            an_d[idx_q] = 1'b0;
            sseg_d      = lz_mask[idx_q] ? 8'hFF : hex_glyph(disp_q[4*idx_q +: 4]);
            if (ddp_q[idx_q]) begin
                sseg_d[0] = 1'b0;
            end
            if (blink_hide) begin
                sseg_d = 8'hFF;
            end
        end
    end

    always_ff @(posedge clk_out) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            sdp_q        <= '0;
            disp_q       <= '0;
            ddp_q        <= '0;
            pending_q    <= 1'b0;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
            sseg_q       <= 8'hFF;
            an_q         <= '1;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            sdp_q        <= sdp_d;
            disp_q       <= disp_d;
            ddp_q        <= ddp_d;
            pending_q    <= pending_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
            sseg_q       <= sseg_d;
            an_q         <= an_d;
        end
    end

    assign load_ack   = load_ack_q;
    assign frame_done = frame_done_q;
    assign sseg       = sseg_q;
    assign AN         = an_q;

endmodule

`default_nettype wire

// File: tb/tb_sseg_scanner.sv
// tb_sseg_scanner: directed and random stimulus against a frame-position reference model.
`default_nettype none

module tb_sseg_scanner;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int BF = 2;
    localparam int F  = N * D;

    logic            clk_out = 1'b0;
    logic            reset   = 1'b1;
    logic [4*N-1:0]  value   = '0;
    logic [N-1:0]    dp      = '0;
    logic            load    = 1'b0;
    logic            blank_lz = 1'b0;
    logic [N-1:0]    blink   = '0;
    logic            load_ack, frame_done;
    logic [7:0]      sseg;
    logic [N-1:0]    AN;

    sseg_scanner #(.NUM_DIGITS(N), .DWELL_CYCLES(D), .BLINK_FRAMES(BF)) dut (
        .clk_out(clk_out), .reset(reset), .value(value), .dp(dp), .load(load),
        .blank_lz(blank_lz), .blink(blink), .load_ack(load_ack),
        .frame_done(frame_done), .sseg(sseg), .AN(AN)
    );

    always #5 clk_out = ~clk_out;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: position within the frame plus the word bookkeeping.
    int             m_p = 0;
    int             m_frames = 0;
    logic [4*N-1:0] m_disp = '0, m_sh = '0;
    logic [N-1:0]   m_ddp = '0, m_sdp = '0;
    logic           m_pend = 1'b0;
    logic [N-1:0]   exp_an = '1;
    logic [7:0]     exp_seg = 8'hFF;
    logic           exp_ack = 1'b0, exp_fd = 1'b0, exp_seg_valid = 1'b1;

    string segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [7:0] glyph(input int nib);
        logic [7:0] code;
        string s;
        code = 8'hFF;
        s = segs[nib];
        for (int i = 0; i < s.len(); i++) begin
            code[int'(s[i]) - int'("a") + 1] = 1'b0;
        end
        return code;
    endfunction

    task automatic step();
        int dg, c, nib;
        logic blanked;
        @(posedge clk_out);
        if (reset) begin
            m_p = 0; m_frames = 0; m_disp = '0; m_sh = '0; m_ddp = '0; m_sdp = '0;
            m_pend = 1'b0; exp_an = '1; exp_seg = 8'hFF; exp_ack = 1'b0; exp_fd = 1'b0;
            exp_seg_valid = 1'b1;
        end else begin
            dg = m_p / D;
            c  = m_p % D;
            exp_seg_valid = (c != 0);
            exp_an  = (c != 0) ? ~(N'(1) << dg) : '1;
            nib     = int'((m_disp >> (4 * dg)) & 16'hF);
            blanked = blank_lz && (dg != 0) && ((m_disp >> (4 * dg)) == 0);
            exp_seg = blanked ? 8'hFF : glyph(nib);
            if (m_ddp[dg]) exp_seg[0] = 1'b0;
`ifdef SSEG_BLINK_EN
            if ((((m_frames / BF) % 2) == 1) && blink[dg]) exp_seg = 8'hFF;
`endif
            exp_fd  = (m_p == F - 1);
            exp_ack = 1'b0;
            if (m_p == F - 1) begin
                if (load) begin
                    m_disp = value; m_ddp = dp; exp_ack = 1'b1;
                end else if (m_pend) begin
                    m_disp = m_sh; m_ddp = m_sdp; exp_ack = 1'b1;
                end
                m_pend = 1'b0;
                m_frames++;
            end else if (load) begin
                m_sh = value; m_sdp = dp; m_pend = 1'b1;
            end
            m_p = (m_p + 1) % F;
        end
        #1;
        n_cmp++;
        assert (AN === exp_an) else begin
            n_fail++; $error("FAIL an: got %b expected %b (pos %0d)", AN, exp_an, m_p);
        end
        n_cmp++;
        assert (load_ack === exp_ack) else begin
            n_fail++; $error("FAIL load_ack: got %b expected %b", load_ack, exp_ack);
        end
        n_cmp++;
        assert (frame_done === exp_fd) else begin
            n_fail++; $error("FAIL frame_done: got %b expected %b", frame_done, exp_fd);
        end
        if (exp_seg_valid) begin
            n_cmp++;
            assert (sseg === exp_seg) else begin
                n_fail++; $error("FAIL sseg: got %h expected %h (AN %b)", sseg, exp_seg, AN);
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the scanner sits at frame position pp (bounded to one frame).
    task automatic run_to(input int pp);
        for (int i = 0; i < F && m_p != pp; i++) step();
    endtask

    task automatic pulse_load(input logic [4*N-1:0] v, input logic [N-1:0] d);
        value = v; dp = d; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        // Reset and idle scan of the all-zero word.
        reset = 1'b1; steps(3);
        reset = 1'b0; steps(2 * F);

        // Load at cnt=1, idx=0; acknowledged at the frame boundary.
        run_to(1);
        pulse_load(16'h1A08, 4'b0000);
        steps(2 * F);

        // Two loads in one frame give a single acknowledge.
        run_to(2);
        pulse_load(16'h1111, 4'b0000);
        run_to(9);
        pulse_load(16'h2222, 4'b0000);
        steps(2 * F);

        // Leading-zero blanking with a decimal point on a blanked digit.
        blank_lz = 1'b1;
        run_to(3);
        pulse_load(16'h0010, 4'b0100);
        steps(2 * F);

        // Reset while a load is pending discards it.
        run_to(4);
        pulse_load(16'hBEEF, 4'b1111);
        steps(3);
        reset = 1'b1; steps(2);
        reset = 1'b0; steps(2 * F);

        // Load exactly on the boundary edge.
        blank_lz = 1'b0;
        run_to(F - 1);
        pulse_load(16'hC3D5, 4'b1001);
        steps(F);

        // Blink on digit 0 over eight frames from reset.
        reset = 1'b1; step();
        reset = 1'b0; blink = 4'b0001;
        run_to(1);
        pulse_load(16'h6E79, 4'b0010);
        steps(8 * F);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            load  = ($urandom_range(0, 9) == 0);
            value = 16'($urandom);
            dp    = 4'($urandom);
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 99) == 0) blink = 4'($urandom);
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        load = 1'b0; reset = 1'b0;
        steps(F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
